rtc_set_controller: RTL
=======================

RTC_SET_CONTROLLER -- requirements
Module: rtc_set_controller

Interface
REQ-001 Parameter MAX_HOUR, default 23: highest hour value; hour wraps MAX_HOUR->0.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 tick_1hz  input  1  single-cycle enable, one per second.
REQ-005 btn_mode  input  1  debounced single-cycle pulse; advances mode.
REQ-006 btn_inc  input  1  debounced single-cycle pulse; increments selected field.
REQ-007 hours  output  5  current hour, 0..MAX_HOUR.
REQ-008 minutes  output  6  current minute, 0..59.
REQ-009 seconds  output  6  current second, 0..59.
REQ-010 mode  output  3  state code: RUN=0, SET_H=1, SET_M=2, SET_S=3, SET_AH=4, SET_AM=5.
REQ-011 blink  output  1  display blink for the field being set.
REQ-012 day_pulse  output  1  one-cycle pulse on MAX_HOUR:59:59 -> 00:00:00 rollover.
REQ-013 alarm_hit  output  1  one-cycle alarm pulse.

Function
REQ-014 All outputs SHALL be registered; a response to any input pulse appears one clk cycle after the pulse is sampled.
REQ-015 States SHALL advance on btn_mode: RUN->SET_H->SET_M->SET_S->RUN (alarm states per REQ-027).
REQ-016 In RUN, each tick_1hz SHALL increment seconds; 59->0 SHALL carry to minutes; minutes 59->0 SHALL carry to hours; hours MAX_HOUR->0 wraps.
REQ-017 day_pulse SHALL be high for exactly the cycle in which time shows 00:00:00 after a rollover from RUN counting; never from btn_inc.
REQ-018 In any SET state, tick_1hz SHALL NOT advance time; time is frozen.
REQ-019 btn_inc in SET_H/SET_M/SET_S SHALL increment only that field, wrapping (MAX_HOUR->0, 59->0) with no carry into other fields.
REQ-020 btn_inc in RUN SHALL be ignored.
REQ-021 btn_mode and btn_inc in the same cycle: mode transition applied, btn_inc ignored.
REQ-022 tick_1hz and btn_mode in the same cycle in RUN: tick increment applied and transition to SET_H taken.
REQ-023 blink SHALL be 0 in RUN; in SET states it SHALL toggle on each tick_1hz; it SHALL be forced to 1 on entering any SET state.
REQ-024 Field values SHALL never leave their legal ranges; no illegal state code SHALL ever appear on mode; unused codes recover to RUN next cycle.

Reset
REQ-025 reset SHALL asynchronously force mode=RUN, hours=0, minutes=0, seconds=0, blink=0, day_pulse=0, alarm_hit=0 and alarm registers=0.
REQ-026 Reset asserted mid-SET SHALL discard partial edits; after deassertion the block starts in RUN at 00:00:00 and counts on the next tick_1hz.

Configuration
REQ-027 With RTC_ALARM_EN defined: sequence SHALL be RUN->SET_H->SET_M->SET_S->SET_AH->SET_AM->RUN; btn_inc in SET_AH/SET_AM increments alarm hour (0..MAX_HOUR) / alarm minute (0..59) with wrap; in these states hours/minutes/seconds outputs show the running-frozen time and blink follows REQ-023.
REQ-028 With RTC_ALARM_EN defined: alarm_hit SHALL pulse one cycle when, in RUN, a tick transitions time to alarm_hour:alarm_minute:00; manual edits never trigger it.
REQ-029 Without RTC_ALARM_EN: no alarm registers; SET_S->RUN; alarm_hit SHALL be constant 0; codes 4 and 5 never appear.

Verification
REQ-030 Reset, 60 ticks in RUN -> 00:01:00, day_pulse never high.
REQ-031 Preload 23:59:59 via SET states, return to RUN, one tick -> 00:00:00 with day_pulse high one cycle.
REQ-032 In SET_M at 00:59:00, btn_inc -> minutes=0, hours still 0; 5 ticks -> seconds unchanged, blink toggles 5 times.
REQ-033 btn_mode and btn_inc same cycle in SET_H at hour 5 -> mode=SET_M, hours=5.
REQ-034 Assert reset during SET_H after 3 btn_inc -> mode=RUN, 00:00:00 immediately (async).
REQ-035 RTC_ALARM_EN: alarm 00:02, run from 00:01:58 -> alarm_hit one cycle at 00:02:00; without macro alarm_hit stays 0 and mode goes 3->0.

Source files
------------

// File: rtl/rtc_set_controller.sv
// Real-time clock with a button-driven set mode.
// Counts seconds, minutes and hours from tick_1hz while in RUN. btn_mode steps
// through the time-set states and btn_inc increments the field being set.
// Optional alarm support is enabled by defining RTC_ALARM_EN. Without it, the
// alarm registers are absent and alarm_hit is held at 0.
module rtc_set_controller #(
  parameter int MAX_HOUR = 23
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [2:0] mode,
  output logic       blink,
  output logic       day_pulse,
  output logic       alarm_hit
);

  localparam logic [4:0] MAX_H  = MAX_HOUR[4:0];
  localparam logic [5:0] MAX_MS = 6'd59;

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    SET_H  = 3'd1,
    SET_M  = 3'd2,
    SET_S  = 3'd3,
    SET_AH = 3'd4,
    SET_AM = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] hours_q, hours_d;
  logic [5:0] minutes_q, minutes_d;
  logic [5:0] seconds_q, seconds_d;
  logic       blink_q, blink_d;
  logic       day_pulse_q, day_pulse_d;
  logic       alarm_hit_q, alarm_hit_d;
`ifdef RTC_ALARM_EN
  logic [4:0] alarm_h_q, alarm_h_d;
  logic [5:0] alarm_m_q, alarm_m_d;
`endif

  // The state that follows the current one on a btn_mode press.
  function automatic state_t next_mode(input state_t s);
    case (s)
      RUN:     next_mode = SET_H;
      SET_H:   next_mode = SET_M;
      SET_M:   next_mode = SET_S;
`ifdef RTC_ALARM_EN
      SET_S:   next_mode = SET_AH;
      SET_AH:  next_mode = SET_AM;
`endif
      default: next_mode = RUN;
    endcase
  endfunction

  // Next-state logic for the mode FSM, the time fields, blink and the event pulses.
  always_comb begin
    state_d     = state_q;
    hours_d     = hours_q;
    minutes_d   = minutes_q;
    seconds_d   = seconds_q;
    blink_d     = blink_q;
    day_pulse_d = 1'b0;
    alarm_hit_d = 1'b0;
`ifdef RTC_ALARM_EN
    alarm_h_d   = alarm_h_q;
    alarm_m_d   = alarm_m_q;
`endif
    case (state_q)
      RUN: begin
        blink_d = 1'b0;
        if (tick_1hz) begin
          if (seconds_q == MAX_MS) begin
            seconds_d = '0;
            if (minutes_q == MAX_MS) begin
              minutes_d = '0;
              if (hours_q == MAX_H) begin
                hours_d     = '0;
                day_pulse_d = 1'b1;
              end else begin
                hours_d = hours_q + 5'd1;
              end
            end else begin
              minutes_d = minutes_q + 6'd1;
            end
          end else begin
            seconds_d = seconds_q + 6'd1;
          end
`ifdef RTC_ALARM_EN
          alarm_hit_d = (hours_d == alarm_h_q) && (minutes_d == alarm_m_q) &&
                        (seconds_d == '0);
`endif
        end
        // A press that coincides with a tick keeps the tick's increment.
        if (btn_mode) begin
          state_d = SET_H;
          blink_d = 1'b1;
        end
      end
      SET_H, SET_M, SET_S
`ifdef RTC_ALARM_EN
      , SET_AH, SET_AM
`endif
      : begin
        if (btn_mode) begin
          // A simultaneous btn_inc is dropped. Blink restarts lit in the new field.
          state_d = next_mode(state_q);
          blink_d = (next_mode(state_q) != RUN);
        end else begin
          if (btn_inc) begin
            case (state_q)
              SET_H:   hours_d   = (hours_q   == MAX_H)  ? '0 : hours_q   + 5'd1;
              SET_M:   minutes_d = (minutes_q == MAX_MS) ? '0 : minutes_q + 6'd1;
              SET_S:   seconds_d = (seconds_q == MAX_MS) ? '0 : seconds_q + 6'd1;
`ifdef RTC_ALARM_EN
              SET_AH:  alarm_h_d = (alarm_h_q == MAX_H)  ? '0 : alarm_h_q + 5'd1;
              SET_AM:  alarm_m_d = (alarm_m_q == MAX_MS) ? '0 : alarm_m_q + 6'd1;
`endif
              default: ;
            endcase
          end
          if (tick_1hz) blink_d = ~blink_q;
        end
      end
      default: begin
        state_d = RUN;
        blink_d = 1'b0;
      end
    endcase
  end

  // All state and output registers, with an asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      hours_q     <= '0;
      minutes_q   <= '0;
      seconds_q   <= '0;
      blink_q     <= 1'b0;
      day_pulse_q <= 1'b0;
      alarm_hit_q <= 1'b0;
`ifdef RTC_ALARM_EN
      alarm_h_q   <= '0;
      alarm_m_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      hours_q     <= hours_d;
      minutes_q   <= minutes_d;
      seconds_q   <= seconds_d;
      blink_q     <= blink_d;
      day_pulse_q <= day_pulse_d;
      alarm_hit_q <= alarm_hit_d;
`ifdef RTC_ALARM_EN
      alarm_h_q   <= alarm_h_d;
      alarm_m_q   <= alarm_m_d;
`endif
    end
  end

  assign hours     = hours_q;
  assign minutes   = minutes_q;
  assign seconds   = seconds_q;
  assign mode      = state_q;
  assign blink     = blink_q;
  assign day_pulse = day_pulse_q;
  assign alarm_hit = alarm_hit_q;

endmodule
